fir_out_requant: RTL and testbench

Output requantiser for the symmetric 16-tap FIR in the audio loopback path. It consumes the FIR's 29-bit signed accumulator output and its one-cycle `valid` strobe. It applies a programmable rounding right shift, saturates the result to 16-bit PCM and buffers the samples in a small first-word-fall-through FIFO. Samples leave through a valid/ready handshake toward the DAC/I2S transmit side, and the block counts saturation and overflow-drop events for debug.

---
 rtl/fir_out_pkg.sv | 17 +
 rtl/sync_fifo_fwft.sv | 72 +++++++
 rtl/fir_out_requant.sv | 144 ++++++++++++++
 tb/tb_fir_out_requant.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fir_out_pkg.sv
// Shared constants and helpers for the FIR output requantiser.
package fir_out_pkg;

  localparam int DIN_W_DEF  = 29;
  localparam int DOUT_W_DEF = 16;

  localparam logic signed [15:0] PCM_MAX = 16'sh7FFF;
  localparam logic signed [15:0] PCM_MIN = 16'sh8000;

  localparam logic [3:0] SHIFT_MAX = 4'd13;

  // Shift codes above SHIFT_MAX behave as SHIFT_MAX.
  function automatic logic [3:0] clamp_shift(input logic [3:0] s);
    return (s > SHIFT_MAX) ? SHIFT_MAX : s;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with level/full/empty status.
//
// Handshake: a word leaves when o_valid && i_rd_en in the same cycle; o_rd_data
// always shows the head word and stays constant until that pop. A write is
// accepted when i_wr_en && (!o_full || pop in the same cycle); a write offered
// while full with no pop is ignored and the caller accounts for it.
module sync_fifo_fwft
  import fir_out_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_wr_en,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  output logic [W-1:0]  o_rd_data,
  output logic          o_valid,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  logic w_full;
  logic w_empty;
  logic w_rd_fire;
  logic w_wr_fire;

  assign w_full    = (r_level == FULL_LVL);
  assign w_empty   = (r_level == '0);
  assign w_rd_fire = i_rd_en && !w_empty;
  assign w_wr_fire = i_wr_en && (!w_full || w_rd_fire);

  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_valid   = !w_empty;
  assign o_level   = r_level;
  // Show zero rather than stale storage whenever nothing is queued.
  assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array: written at the write pointer, no reset needed.
  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_fire, w_rd_fire})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_requant.sv
// FIR output requantiser: rounding shift (P1), PCM clamp (P2), FWFT buffer
// toward the DAC side, plus saturation/drop statistics.
module fir_out_requant
  import fir_out_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  input  logic [DIN_W-1:0]           in_data,
  input  logic [3:0]                 shift,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DOUT_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       sat_flag,
  output logic [15:0]                sat_cnt,
  output logic [15:0]                drop_cnt,
  input  logic                       clr_stat
);

  localparam int AW = $clog2(DEPTH);

  // Clamp limits widened to the P1 width (sign-extending casts).
  localparam logic signed [DIN_W:0] LIM_HI = (DIN_W+1)'(PCM_MAX);
  localparam logic signed [DIN_W:0] LIM_LO = (DIN_W+1)'(PCM_MIN);

  logic                     r_p1_valid;
  logic signed [DIN_W:0]    r_p1_data;
  logic                     r_p2_valid;
  logic [DOUT_W-1:0]        r_p2_data;
  logic                     r_p2_sat;

  logic                     r_sat_flag;
  logic [15:0]              r_sat_cnt;
  logic [15:0]              r_drop_cnt;

  logic [3:0]               w_shift;
  logic signed [DIN_W:0]    w_ext;
  logic signed [DIN_W:0]    w_bias;
  logic signed [DIN_W:0]    w_sum;
  logic signed [DIN_W:0]    w_p1_next;
  logic [DOUT_W-1:0]        w_p2_next;
  logic                     w_p2_sat;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_accept;
  logic                     w_drop;

  // Rounding right shift; headroom of one extra bit keeps the bias add exact.
  always_comb begin
    w_shift   = clamp_shift(shift);
    w_ext     = $signed({in_data[DIN_W-1], in_data});
    w_bias    = '0;
    if (w_shift != 4'd0)
      w_bias = $signed({{DIN_W{1'b0}}, 1'b1} << (w_shift - 4'd1));
    w_sum     = w_ext + w_bias;
    w_p1_next = w_sum >>> w_shift;
  end

  // Clamp to the PCM range and flag samples that were changed by it.
  always_comb begin
    w_p2_next = r_p1_data[DOUT_W-1:0];
    w_p2_sat  = 1'b0;
    if (r_p1_data > LIM_HI) begin
      w_p2_next = PCM_MAX;
      w_p2_sat  = 1'b1;
    end else if (r_p1_data < LIM_LO) begin
      w_p2_next = PCM_MIN;
      w_p2_sat  = 1'b1;
    end
  end

  // P1/P2 pipeline registers; data only loads with its valid bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_p1_valid <= 1'b0;
      r_p1_data  <= '0;
      r_p2_valid <= 1'b0;
      r_p2_data  <= '0;
      r_p2_sat   <= 1'b0;
    end else begin
      r_p1_valid <= in_valid;
      if (in_valid) r_p1_data <= w_p1_next;
      r_p2_valid <= r_p1_valid;
      if (r_p1_valid) begin
        r_p2_data <= w_p2_next;
        r_p2_sat  <= w_p2_sat;
      end
    end
  end

  // When full, a same-cycle pop (head is valid) makes room for the write.
  assign w_accept = r_p2_valid && (!w_full || out_ready);
  assign w_drop   = r_p2_valid && w_full && !out_ready;

  // Statistics: clear wins over any same-cycle event, counters stick at max.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sat_flag <= 1'b0;
      r_sat_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (clr_stat) begin
      r_sat_flag <= 1'b0;
      r_sat_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (r_p2_valid && r_p2_sat) r_sat_flag <= 1'b1;
      if (w_accept && r_p2_sat && (r_sat_cnt != 16'hFFFF))
        r_sat_cnt <= r_sat_cnt + 16'd1;
      if (w_drop && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  sync_fifo_fwft #(
    .W     (DOUT_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .i_wr_en   (w_accept),
    .i_wr_data (r_p2_data),
    .i_rd_en   (out_ready),
    .o_rd_data (out_data),
    .o_valid   (out_valid),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (fifo_level)
  );

  assign sat_flag = r_sat_flag;
  assign sat_cnt  = r_sat_cnt;
  assign drop_cnt = r_drop_cnt;

  // Empty status is carried for completeness; out_valid already reflects it.
  logic w_unused;
  assign w_unused = w_empty;

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant with hand-computed expected samples.
module tb_fir_out_requant;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic [28:0] in_data = '0;
  logic [3:0]  shift = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [3:0]  fifo_level;
  logic        sat_flag;
  logic [15:0] sat_cnt;
  logic [15:0] drop_cnt;
  logic        clr_stat = 1'b0;

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] exp_q[$];

  fir_out_requant dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .shift      (shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .sat_flag   (sat_flag),
    .sat_cnt    (sat_cnt),
    .drop_cnt   (drop_cnt),
    .clr_stat   (clr_stat)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle input strobe.
  task automatic send(input int v, input logic [3:0] s);
    in_valid = 1'b1;
    in_data  = 29'(v);
    shift    = s;
    step();
    in_valid = 1'b0;
  endtask

  // Check head against the scoreboard, then pop it.
  task automatic pop_chk(input string tag);
    logic [15:0] e;
    e = exp_q.pop_front();
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, {16'd0, out_data}, {16'd0, e});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop_chk(tag);
    chk({tag, "_level0"}, {28'd0, fifo_level}, 32'd0);
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_level", {28'd0, fifo_level}, 32'd0);
    chk("rst_satf", {31'd0, sat_flag}, 32'd0);
    chk("rst_satc", {16'd0, sat_cnt}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    rstn = 1'b1;
    step();

    // Positive rounding and three-cycle latency: (74624+128)>>8 = 292
    send(74624, 4'd8);
    chk("lat_n1", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_n2", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_n3", {31'd0, out_valid}, 32'd1);
    chk("rnd_pos", {16'd0, out_data}, 32'h0124);
    chk("rnd_pos_satf", {31'd0, sat_flag}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("rnd_pos_level", {28'd0, fifo_level}, 32'd0);

    // Negative rounding, pass-through, shift code clamp (15/14 act as 13)
    exp_q.push_back(16'hFFFF);   // (-384+128)>>>8 = -1
    exp_q.push_back(16'hFFFB);   // -5 unshifted
    exp_q.push_back(16'h0001);   // (4096+4096)>>>13 = 1
    exp_q.push_back(16'h0000);   // (4095+4096)>>>13 = 0
    send(-384, 4'd8);
    send(-5, 4'd0);
    send(4096, 4'd15);
    send(4095, 4'd14);
    step();
    step();
    chk("rnd_level", {28'd0, fifo_level}, 32'd4);
    drain("rnd");

    // Saturation both ways, in-range max does not count
    send(40000, 4'd0);
    send(-40000, 4'd0);
    send(32767, 4'd0);
    step();
    step();
    chk("sat_flag", {31'd0, sat_flag}, 32'd1);
    chk("sat_cnt", {16'd0, sat_cnt}, 32'd2);
    chk("sat_drop", {16'd0, drop_cnt}, 32'd0);
    exp_q.push_back(16'h7FFF);
    exp_q.push_back(16'h8000);
    exp_q.push_back(16'h7FFF);
    drain("sat");
    clr_stat = 1'b1;
    step();
    clr_stat = 1'b0;
    chk("clr_flag", {31'd0, sat_flag}, 32'd0);
    chk("clr_satc", {16'd0, sat_cnt}, 32'd0);
    chk("clr_drop", {16'd0, drop_cnt}, 32'd0);

    // Overflow: 10 samples into 8 slots with no reads
    for (int i = 1; i <= 10; i++) send(i, 4'd0);
    step();
    step();
    chk("ovf_level", {28'd0, fifo_level}, 32'd8);
    chk("ovf_drop", {16'd0, drop_cnt}, 32'd2);
    chk("ovf_satc", {16'd0, sat_cnt}, 32'd0);
    for (int i = 1; i <= 8; i++) exp_q.push_back(16'(i));
    drain("ovf");

    // Full with a pop in the same cycle as the write
    for (int i = 11; i <= 18; i++) send(i, 4'd0);
    step();
    step();
    chk("rw_full", {28'd0, fifo_level}, 32'd8);
    send(19, 4'd0);
    step();
    out_ready = 1'b1;
    chk("rw_head", {16'd0, out_data}, 32'd11);
    step();
    out_ready = 1'b0;
    chk("rw_level", {28'd0, fifo_level}, 32'd8);
    chk("rw_drop", {16'd0, drop_cnt}, 32'd2);
    for (int i = 12; i <= 19; i++) exp_q.push_back(16'(i));
    drain("rw");

    // Reset with 5 words queued and two more in the pipeline
    for (int i = 21; i <= 25; i++) send(i, 4'd0);
    step();
    step();
    chk("mr_level5", {28'd0, fifo_level}, 32'd5);
    send(26, 4'd0);
    send(27, 4'd0);
    rstn = 1'b0;
    #1;
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_level", {28'd0, fifo_level}, 32'd0);
    chk("mr_data", {16'd0, out_data}, 32'd0);
    chk("mr_drop", {16'd0, drop_cnt}, 32'd0);
    step();
    step();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_idle", {28'd0, fifo_level}, 32'd0);
    end
    send(77, 4'd0);
    chk("mr_lat1", {31'd0, out_valid}, 32'd0);
    step();
    chk("mr_lat2", {31'd0, out_valid}, 32'd0);
    step();
    exp_q.push_back(16'd77);
    drain("mr_first");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
